// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// State encoding, hold counter width and an index helper.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int HOLD_W = 8;

    // Return the index one above idx, wrapping at the N-bit boundary.
    function automatic logic [7:0] wrap_inc(input logic [7:0] idx, input int n);
        logic [7:0] mask;
        mask = 8'((1 << n) - 1);
        return (idx + 8'd1) & mask;
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_decoder.sv
// N-bit to one-hot decoder with enable.
// Output is all zero while enable is low.
module DecoderNbit #(
    parameter int N = 3
) (
    input  logic [N-1:0]      a,
    input  logic              enable,
    output logic [2**N-1:0]   y
);

    // One-hot decode of a, gated by enable.
    always_comb begin
        y = '0;
        if (enable) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 2**N requesters with bounded hold time.
// One-hot grant comes from the shared N-bit decoder.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2**N-1:0]   req,
    input  logic              release_i,
    output logic [2**N-1:0]   gnt,
    output logic [N-1:0]      gnt_idx,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam int R = 2**N;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state;
    logic [N-1:0]       ptr;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               found;
    logic [N-1:0]       pick;
    logic [N-1:0]       cand;

    logic               cause_drop;
    logic               cause_rel;
    logic               cause_hold;
    logic               grant_end;
    logic [N-1:0]       next_ptr;

    // Rotating search: first set request at or above ptr, modulo R.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int i = 0; i < R; i++) begin
            cand = ptr + N'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Grant end causes; drop and release take precedence over timeout.
    always_comb begin
        cause_drop = !req[gnt_idx];
        cause_rel  = release_i;
        cause_hold = (hold_cnt == HOLD_LAST);
        grant_end  = cause_drop || cause_rel || cause_hold;
        next_ptr   = N'(wrap_inc(8'(gnt_idx), N));
    end

    // Arbitration FSM with registered timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt_idx  <= pick;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        ptr     <= next_ptr;
                        state   <= IDLE;
                        timeout <= cause_hold && !cause_drop && !cause_rel;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_valid = (state == GRANT);

    DecoderNbit #(
        .N(N)
    ) u_dec (
        .a      (gnt_idx),
        .enable (gnt_valid),
        .y      (gnt)
    );

endmodule
